// File: rtl/manchester_rx_pkg.sv
// Shared types and width helpers for the Manchester frame receiver.
package manchester_rx_pkg;

  // Receiver frame states: hunting, preamble low, preamble high, payload.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC_LO = 2'd1,
    SYNC_HI = 2'd2,
    DATA    = 2'd3
  } rx_state_t;

  // Width of a phase counter spanning one full Manchester bit.
  function automatic int phase_w(input int half_bit);
    return (half_bit < 1) ? 1 : $clog2(2 * half_bit);
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/manchester_bit_sampler.sv
// Oversampled Manchester bit sampler: tracks the phase inside each bit,
// captures the first-half sample and flags a decoded bit or a violation
// in the cycle the second-half sample is taken.
module manchester_bit_sampler
  import manchester_rx_pkg::*;
#(
  parameter int HALF_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic in,
  output logic bit_evt,
  output logic bit_val,
  output logic viol
);

  localparam int PHASE_W = phase_w(HALF_BIT);
  localparam logic [PHASE_W-1:0] S1_PH   = PHASE_W'(HALF_BIT / 2 - 1);
  localparam logic [PHASE_W-1:0] S2_PH   = PHASE_W'(HALF_BIT + HALF_BIT / 2 - 1);
  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(2 * HALF_BIT - 1);

  logic [PHASE_W-1:0] phase_r;
  logic               s1_r;
  logic               s2_cyc_s;

  // Phase counter held at zero outside the payload so each frame starts aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= '0;
      s1_r    <= 1'b0;
    end else if (!run) begin
      phase_r <= '0;
      s1_r    <= 1'b0;
    end else begin
      if (phase_r == LAST_PH) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PHASE_W'(1);
      end
      if (phase_r == S1_PH) begin
        s1_r <= in;
      end
    end
  end

  // A valid Manchester bit needs opposite levels in its two halves.
  always_comb begin
    s2_cyc_s = run && (phase_r == S2_PH);
    bit_evt  = s2_cyc_s && (in != s1_r);
    viol     = s2_cyc_s && (in == s1_r);
    bit_val  = in;
  end

endmodule

// File: rtl/manchester_frame_rx.sv
// Manchester frame receiver: preamble detection, payload assembly,
// optional parity check, error reporting and a frame counter.
module manchester_frame_rx
  import manchester_rx_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int HALF_BIT   = 4,
  parameter int SYNC_LEN   = 12,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic                 bit_strobe,
  output logic                 bit_data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 word_valid,
  output logic                 parity_err,
  output logic                 code_err,
  output logic [7:0]           frame_cnt,
  output logic                 busy
);

  localparam int CNT_W = cnt_w(SYNC_LEN);
  localparam int NBITS = DATA_BITS + ((PARITY_EN != 0) ? 1 : 0);
  localparam int IDX_W = cnt_w(NBITS);
  localparam logic [CNT_W-1:0] SYNC_MAX     = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] SYNC_HI_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NBITS - 1);
  localparam logic [IDX_W-1:0] PAY_BITS     = IDX_W'(DATA_BITS);
  localparam logic             ACC_SEED     = (PARITY_ODD != 0);
  localparam logic             PAR_ON       = (PARITY_EN != 0);

  rx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic                 acc_r;
  logic                 run_s;
  logic                 bit_evt_s;
  logic                 bit_val_s;
  logic                 viol_s;

  assign run_s = (state_r == DATA);
  // busy is a pure decode of the state register.
  assign busy  = (state_r != IDLE);

  manchester_bit_sampler #(
    .HALF_BIT(HALF_BIT)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .in      (in),
    .bit_evt (bit_evt_s),
    .bit_val (bit_val_s),
    .viol    (viol_s)
  );

  // Next assembly value: payload bits shift in MSB first, the parity bit does not.
  always_comb begin
    if (idx_r < PAY_BITS) begin
      shift_nxt_s = DATA_BITS'({shift_r, bit_val_s});
    end else begin
      shift_nxt_s = shift_r;
    end
  end

  // Frame FSM with registered outputs. The first high sample is taken on the
  // SYNC_LO exit (cnt=1), so DATA starts on the edge where the high count
  // reaches SYNC_LEN; phase 0 then lines up with the first payload clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      shift_r    <= '0;
      acc_r      <= ACC_SEED;
      bit_strobe <= 1'b0;
      bit_data   <= 1'b0;
      data_out   <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      code_err   <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      bit_strobe <= 1'b0;
      bit_data   <= 1'b0;
      word_valid <= 1'b0;
      code_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!in) begin
            state_r <= SYNC_LO;
            cnt_r   <= CNT_W'(1);
            shift_r <= '0;
            acc_r   <= ACC_SEED;
          end
        end
        SYNC_LO: begin
          if (!in) begin
            if (cnt_r != SYNC_MAX) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else if (cnt_r >= SYNC_MAX) begin
            state_r <= SYNC_HI;
            cnt_r   <= CNT_W'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        SYNC_HI: begin
          if (!in) begin
            state_r <= IDLE;
          end else if (cnt_r == SYNC_HI_LAST) begin
            state_r <= DATA;
            idx_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (viol_s) begin
            code_err <= 1'b1;
            state_r  <= IDLE;
          end else if (bit_evt_s) begin
            bit_strobe <= 1'b1;
            bit_data   <= bit_val_s;
            shift_r    <= shift_nxt_s;
            acc_r      <= acc_r ^ bit_val_s;
            idx_r      <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              word_valid <= 1'b1;
              data_out   <= shift_nxt_s;
              parity_err <= PAR_ON ? (acc_r ^ bit_val_s) : 1'b0;
              frame_cnt  <= frame_cnt + 8'd1;
              state_r    <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
